operand_packer: RTL and testbench
=================================

# operand_packer

Inverse of the operand transformation path: accepts a block of 32 wide signed elements (FU results) and re-encodes it into the micro-scaled narrow operand format, with one micro-scale per element group. Sits on the writeback side of the vector datapath, feeding the operand buffer that the operand transformer later reads. Iterative datapath: one scale pass, then two quantize passes (even and odd elements) over 16 shared lanes, with a single-entry output register and a valid/ready handshake on both sides.

## Interface
Parameters (shared-package constants):
- WIDE_W, 16, signed input element width
- NARROW_W, 8, signed packed element width
- SCALE_W, 4, micro-scale width; legal shift values are 0..8
- N_ELEM, 32, elements per block

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- valid_in  in  1  input block valid
- ready_in  out  1  packer can accept a block
- data_in  in  pack_input_t  elements[32] (WIDE_W signed) plus cfg (config_t)
- ready_out  in  1  downstream accepts the packed block
- valid_out  out  1  packed block valid
- data_out  out  pack_output_t  elements[32] (NARROW_W signed), micro_scales[16] (SCALE_W), cfg

## Operation
- FSM states: IDLE, SCALE, Q_EVEN, Q_ODD, DONE.
- IDLE: ready_in=1. On valid_in&&ready_in, capture data_in into the input buffer and go to SCALE. data_in is not sampled again.
- Groups:
  - cfg.scale_sharing_mode=0: group k = elements {2k, 2k+1}, k=0..15.
  - cfg.scale_sharing_mode=1: group k = elements {4k..4k+3}, k=0..7; micro_scales[8..15]=0.
- SCALE: per group, s = smallest value in 0..8 such that every element x in the group satisfies (x >>> s) in [-128, 127]. Register all scales, then go to Q_EVEN.
- Q_EVEN: lane i quantizes element 2i using its group's scale and writes the result to a temp register. Then go to Q_ODD.
- Q_ODD: lane i quantizes element 2i+1. The output register loads all 32 elements, the scales and cfg at the end of this cycle. Then go to DONE.
- Quantization (default): q = x >>> s, an arithmetic shift that floors toward negative infinity. The result always fits in NARROW_W.
- DONE: valid_out=1. On ready_out, go to IDLE.
- data_out holds stable while valid_out=1 and ready_out=0.
- ready_in=0 in every state except IDLE, so there is no block overlap.

## Timing
- Reset (asynchronous): FSM goes to IDLE. valid_out=0, data_out=0, scale/temp/input registers=0, ready_in=1.
- Accept handshake at edge T: states are SCALE in T+1, Q_EVEN in T+2, Q_ODD in T+3. valid_out=1 from T+4.
- Minimum accept-to-accept interval is 5 cycles: DONE handshake at edge D, ready_in=1 in D+1.
- valid_in=1 outside IDLE is ignored, and the input is not captured.
- ready_out=1 before valid_out has no effect.
- Reset mid-block drops the block with no partial output. valid_out returns to 0 immediately (asynchronous).

## Configuration
- OPERAND_PACK_ROUND_EN defined: for s>0, q = sat8((x + 2^(s-1)) >>> s), i.e. round-half-up with saturation to [-128, 127]. For s=0, q=x. Scale selection is unchanged.
- OPERAND_PACK_ROUND_EN undefined: truncating arithmetic shift as described in Operation, with no rounding adder or saturation logic.

## Structure
- Shared package operand_tf_pkg holds:
  - WIDE_W, NARROW_W, SCALE_W, N_ELEM
  - pack_input_t and pack_output_t
  - the existing config_t, reused unchanged
  - the FSM state enum pack_state_t
- Sub-module operand_pack_lane: one quantizer (shift, optional rounding and saturation) plus its temp result register. The top instantiates 16 of them.
- Lane scale select: micro_scale[i/2] when scale_sharing_mode=1, else micro_scale[i]. The top holds the scale-computation logic and the FSM.

## Test plan
- Mode 0, elements[0]=300, elements[1]=-5, all others 0 -> micro_scales[0]=2, out[0]=75, out[1]=-2 (rounding build: -1); all other scales and elements 0; valid_out exactly 4 cycles after accept.
- Mode 1, elements[0..3]={-32768,0,0,0} -> micro_scales[0]=8, out[0]=-128; micro_scales[8..15]=0.
- Rounding build, mode 0, elements[4]=32767 -> micro_scales[2]=8, out[4]=127 (saturated); non-rounding build -> out[4]=127 by truncation.
- Backpressure: hold ready_out=0 for 10 cycles in DONE -> data_out stable, ready_in=0, a second valid_in is not captured; release -> ready_in=1 next cycle, and the second block is accepted and correct.
- Elements already in [-128, 127] -> all scales 0, output equals input bit-for-bit (sign-truncated).
- Assert rst_n during Q_EVEN -> valid_out=0 and data_out=0 immediately; the next block processes correctly with no residue from the aborted block.

Source files
------------

// File: rtl/operand_tf_pkg.sv
// Shared types and constants for the operand transform/pack datapath.
// OPERAND_PACK_ROUND_EN selects round-half-up with saturation in the packer quantizers.
package operand_tf_pkg;

  localparam int WIDE_W   = 16;
  localparam int NARROW_W = 8;
  localparam int SCALE_W  = 4;
  localparam int N_ELEM   = 32;

  localparam int N_GROUPS   = N_ELEM / 2;
  localparam int N_LANES    = N_ELEM / 2;
  localparam int MAX_SHIFT  = 8;
  localparam int NARROW_MAX = (2 ** (NARROW_W - 1)) - 1;
  localparam int NARROW_MIN = -(2 ** (NARROW_W - 1));

  typedef logic [WIDE_W-1:0]   wide_t;
  typedef logic [NARROW_W-1:0] narrow_t;
  typedef logic [SCALE_W-1:0]  scale_t;

  typedef struct packed {
    logic scale_sharing_mode;  // 0: pairs share a scale, 1: quads share a scale
  } config_t;

  typedef struct packed {
    wide_t [N_ELEM-1:0] elements;
    config_t            cfg;
  } pack_input_t;

  typedef struct packed {
    narrow_t [N_ELEM-1:0]  elements;
    scale_t [N_GROUPS-1:0] micro_scales;
    config_t               cfg;
  } pack_output_t;

  typedef enum logic [2:0] {
    IDLE,
    SCALE,
    Q_EVEN,
    Q_ODD,
    DONE
  } pack_state_t;

  function automatic scale_t scale_max(input scale_t a, input scale_t b);
    return (a > b) ? a : b;
  endfunction

  // Smallest shift that brings one element into the narrow signed range.
  function automatic scale_t shift_needed(input wide_t x);
    logic signed [WIDE_W-1:0] sx;
    logic signed [WIDE_W-1:0] t;
    scale_t                   s_min;
    sx    = $signed(x);
    s_min = scale_t'(MAX_SHIFT);
    for (int s = MAX_SHIFT; s >= 0; s--) begin
      t = sx >>> s;
      if (int'(t) >= NARROW_MIN && int'(t) <= NARROW_MAX) s_min = scale_t'(s);
    end
    return s_min;
  endfunction

endpackage

// File: rtl/operand_pack_lane.sv
// One packer quantizer lane: shift by the group scale, plus the even-element temp register.
// OPERAND_PACK_ROUND_EN adds round-half-up and saturation ahead of the narrow result.
module operand_pack_lane
  import operand_tf_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    load,
  input  wide_t   x,
  input  scale_t  shift,
  output narrow_t q,
  output narrow_t q_temp
);

`ifdef OPERAND_PACK_ROUND_EN
  function automatic narrow_t quantize(input wide_t xv, input scale_t s);
    logic signed [WIDE_W:0] ext;
    logic signed [WIDE_W:0] half;
    logic signed [WIDE_W:0] sum;
    logic signed [WIDE_W:0] shifted;
    narrow_t                r;
    ext     = $signed({xv[WIDE_W-1], xv});
    half    = (WIDE_W + 1)'(1) << (s - scale_t'(1));
    sum     = ext + half;
    shifted = sum >>> s;
    if (s == '0) begin
      r = narrow_t'(xv);
    end else if (int'(shifted) > NARROW_MAX) begin
      r = narrow_t'(NARROW_MAX);
    end else if (int'(shifted) < NARROW_MIN) begin
      r = narrow_t'(NARROW_MIN);
    end else begin
      r = narrow_t'(shifted);
    end
    return r;
  endfunction
`else
  // The scale guarantees the floored shift fits, so truncation is lossless here.
  function automatic narrow_t quantize(input wide_t xv, input scale_t s);
    logic signed [WIDE_W-1:0] shifted;
    shifted = $signed(xv) >>> s;
    return narrow_t'(shifted);
  endfunction
`endif

  assign q = quantize(x, shift);

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_temp <= '0;
    end else if (load) begin
      q_temp <= q;
    end
  end

endmodule

// File: rtl/operand_packer.sv
// Re-encodes a block of 32 wide FU results into micro-scaled narrow operands.
// Optional rounding is enabled with OPERAND_PACK_ROUND_EN (see operand_pack_lane).
module operand_packer
  import operand_tf_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_in,
  output logic         ready_in,
  input  pack_input_t  data_in,
  input  logic         ready_out,
  output logic         valid_out,
  output pack_output_t data_out
);

  pack_state_t                 state;
  pack_input_t                 in_buf;
  scale_t [N_GROUPS-1:0]       scale_reg;
  scale_t [N_GROUPS-1:0]       scale_next;
  scale_t [N_ELEM-1:0]         elem_shift;
  narrow_t [N_LANES-1:0]       lane_q;
  narrow_t [N_LANES-1:0]       lane_temp;
  logic                        quad_mode;

  assign quad_mode = in_buf.cfg.scale_sharing_mode;

  always_comb begin
    for (int i = 0; i < N_ELEM; i++) begin
      elem_shift[i] = shift_needed(in_buf.elements[i]);
    end
  end

  // The group scale is the largest per-element requirement; unused quad slots stay zero.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    scale_next = '0;
    if (quad_mode) begin
      for (int k = 0; k < N_GROUPS / 2; k++) begin
        scale_next[k] = scale_max(scale_max(elem_shift[4*k],   elem_shift[4*k+1]),
                                  scale_max(elem_shift[4*k+2], elem_shift[4*k+3]));
      end
    end else begin
      for (int k = 0; k < N_GROUPS; k++) begin
        scale_next[k] = scale_max(elem_shift[2*k], elem_shift[2*k+1]);
      end
    end
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    wide_t  x;
    scale_t sh;

    // Lane i always holds elements 2i and 2i+1, which sit in group i (pairs) or i/2 (quads).
    assign x  = (state == Q_ODD) ? in_buf.elements[2*i+1] : in_buf.elements[2*i];
    assign sh = quad_mode ? scale_reg[i/2] : scale_reg[i];

    operand_pack_lane u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (state == Q_EVEN),
      .x      (x),
      .shift  (sh),
      .q      (lane_q[i]),
      .q_temp (lane_temp[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the wide buffers are reset too, so an aborted block leaves nothing observable behind.
      state     <= IDLE;
      ready_in  <= 1'b1;
      valid_out <= 1'b0;
      in_buf    <= '0;
      scale_reg <= '0;
      data_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in && ready_in) begin
            in_buf   <= data_in;
            ready_in <= 1'b0;
            state    <= SCALE;
          end
        end
        SCALE: begin
          scale_reg <= scale_next;
          state     <= Q_EVEN;
        end
        Q_EVEN: begin
          state <= Q_ODD;
        end
        Q_ODD: begin
          for (int i = 0; i < N_LANES; i++) begin
            data_out.elements[2*i]   <= lane_temp[i];
            data_out.elements[2*i+1] <= lane_q[i];
          end
          data_out.micro_scales <= scale_reg;
          data_out.cfg          <= in_buf.cfg;
          valid_out             <= 1'b1;
          state                 <= DONE;
        end
        DONE: begin
          if (ready_out) begin
            valid_out <= 1'b0;
            ready_in  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          valid_out <= 1'b0;
          ready_in  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_packer.sv
// Self-checking bench for operand_packer: directed plan vectors plus random blocks
// checked against an arithmetic reference model (floor division, range tests).
module tb_operand_packer;
  import operand_tf_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_in = 1'b0;
  logic         ready_out = 1'b0;
  logic         ready_in;
  logic         valid_out;
  pack_input_t  data_in;
  pack_output_t data_out;

  operand_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int stim [N_ELEM];
  bit stim_mode;
  int exp_q [N_ELEM];
  int exp_s [N_GROUPS];
  bit exp_mode;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit fits(input int x, input int s);
    return (x >= -128 * (1 << s)) && (x <= 128 * (1 << s) - 1);
  endfunction

  function automatic int floor_div(input int x, input int s);
    int d;
    d = 1 << s;
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

`ifdef OPERAND_PACK_ROUND_EN
  function automatic int quant(input int x, input int s);
    int v;
    if (s == 0) return x;
    v = floor_div(x + (1 << (s - 1)), s);
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction
`else
  function automatic int quant(input int x, input int s);
    return floor_div(x, s);
  endfunction
`endif

  function automatic bit group_fits(input int k, input int gsz, input int s);
    bit ok;
    ok = 1'b1;
    for (int e = k * gsz; e < (k + 1) * gsz; e++) begin
      if (!fits(stim[e], s)) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic build_expect();
    int gsz;
    int s;
    gsz = stim_mode ? 4 : 2;
    for (int k = 0; k < N_GROUPS; k++) exp_s[k] = 0;
    for (int k = 0; k < N_ELEM / gsz; k++) begin
      s = 0;
      while (s < 8 && !group_fits(k, gsz, s)) s++;
      exp_s[k] = s;
      for (int e = k * gsz; e < (k + 1) * gsz; e++) exp_q[e] = quant(stim[e], s);
    end
    exp_mode = stim_mode;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clear_stim(input bit mode);
    for (int i = 0; i < N_ELEM; i++) stim[i] = 0;
    stim_mode = mode;
  endtask

  task automatic random_stim();
    int w;
    int v;
    stim_mode = 1'($urandom_range(0, 1));
    for (int i = 0; i < N_ELEM; i++) begin
      w = int'($urandom_range(0, 9));
      v = int'($urandom_range(0, 65535)) - 32768;
      stim[i] = (w == 9) ? 0 : (v >>> w);
    end
  endtask

  task automatic drive_block();
    @(negedge clk);
    for (int i = 0; i < N_ELEM; i++) data_in.elements[i] = stim[i][WIDE_W-1:0];
    data_in.cfg.scale_sharing_mode = stim_mode;
    valid_in = 1'b1;
  endtask

  task automatic wait_accept(input string tag);
    int n;
    n = 0;
    while (!ready_in && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_in"}, int'(ready_in), 1);
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  // Called 1 time unit after the accept edge, i.e. in cycle T+1.
  task automatic wait_valid(input string tag);
    int lat;
    lat = 1;
    while (!valid_out && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
  endtask

  task automatic compare_out(input string tag);
    int a;
    for (int i = 0; i < N_ELEM; i++) begin
      a = $signed(data_out.elements[i]);
      check($sformatf("%s_q%0d", tag, i), a, exp_q[i]);
    end
    for (int k = 0; k < N_GROUPS; k++) begin
      check($sformatf("%s_s%0d", tag, k), int'(data_out.micro_scales[k]), exp_s[k]);
    end
    check({tag, "_cfg"}, int'(data_out.cfg.scale_sharing_mode), int'(exp_mode));
  endtask

  function automatic int count_bad();
    int n;
    int a;
    n = 0;
    for (int i = 0; i < N_ELEM; i++) begin
      a = $signed(data_out.elements[i]);
      if (a != exp_q[i]) n++;
    end
    return n;
  endfunction

  task automatic release_out(input string tag);
    @(negedge clk);
    ready_out = 1'b1;
    @(posedge clk);
    #1 ready_out = 1'b0;
    check({tag, "_vout_drop"}, int'(valid_out), 0);
    check({tag, "_rdy_back"}, int'(ready_in), 1);
  endtask

  task automatic run_block(input string tag, input bit early_ready);
    build_expect();
    if (early_ready) ready_out = 1'b1;
    drive_block();
    wait_accept(tag);
    wait_valid(tag);
    compare_out(tag);
    release_out(tag);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    data_in = '0;
    #12;
    check("rst_ready_in", int'(ready_in), 1);
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_dout_nonzero", int'(data_out != '0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pair mode, one group needing shift 2
    clear_stim(1'b0);
    stim[0] = 300;
    stim[1] = -5;
    run_block("t_pair", 1'b0);

    // Abort during Q_EVEN: outputs clear immediately
    random_stim();
    drive_block();
    wait_accept("t_abort");
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_valid_out", int'(valid_out), 0);
    check("abort_dout_nonzero", int'(data_out != '0), 0);
    check("abort_ready_in", int'(ready_in), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Quad mode, most negative input
    clear_stim(1'b1);
    stim[0] = -32768;
    run_block("t_quad_min", 1'b0);

    // Largest positive input
    clear_stim(1'b0);
    stim[4] = 32767;
    run_block("t_pos_max", 1'b0);

    // Already-narrow inputs pass through unscaled
    stim_mode = 1'b1;
    for (int i = 0; i < N_ELEM; i++) stim[i] = int'($urandom_range(0, 255)) - 128;
    stim[0] = -128;
    stim[1] = 127;
    run_block("t_narrow", 1'b0);

    // ready_out raised before valid_out
    random_stim();
    run_block("t_early_rdy", 1'b1);

    // Backpressure with a second block waiting
    random_stim();
    stim_mode = 1'b0;
    build_expect();
    drive_block();
    wait_accept("bp_a");
    wait_valid("bp_a");
    compare_out("bp_a");
    random_stim();
    stim_mode = 1'b1;
    drive_block();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp_stable_c%0d", c), count_bad(), 0);
      check($sformatf("bp_rdy_low_c%0d", c), int'(ready_in), 0);
      check($sformatf("bp_vout_c%0d", c), int'(valid_out), 1);
    end
    ready_out = 1'b1;
    @(posedge clk);
    #1 ready_out = 1'b0;
    check("bp_vout_drop", int'(valid_out), 0);
    check("bp_rdy_back", int'(ready_in), 1);
    build_expect();
    @(posedge clk);
    #1 valid_in = 1'b0;
    wait_valid("bp_b");
    compare_out("bp_b");
    release_out("bp_b");

    // Random blocks
    for (int b = 0; b < 24; b++) begin
      random_stim();
      run_block($sformatf("rnd%0d", b), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
